boot_loader: RTL and testbench

Parametrised serial program loader. It consumes a byte stream from the UART receive path, parses a header (payload length and load address), assembles little-endian words of configurable width, and writes them to a target memory over a valid/ready write port. It sits between the UART receiver and the instruction or data memory arbiter, and holds the core in reset until `done` asserts. It supports non-word-multiple lengths, a restart request, and an optional payload checksum.

---
 rtl/boot_loader_pkg.sv | 25 ++
 rtl/boot_loader_byte_packer.sv | 53 +++++
 rtl/boot_loader.sv | 205 ++++++++++++++++++++
 tb/tb_boot_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and elaboration helpers for the serial boot loader.
// Optional checksum support is selected with BOOT_LOADER_CHECKSUM_EN.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR_LEN,
        ST_HDR_ADDR,
        ST_PAYLOAD,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } boot_state_t;

    // Number of bytes in each header field (length and base address).
    function automatic int hdr_field_bytes(input int addr_w);
        return addr_w / 8;
    endfunction

    // Index width that stays legal (>= 1 bit) for single-entry counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Lane-indexed byte-to-word assembler; closing a word clears it so that
// the lanes of a following partial word read as zero.
module byte_packer
    import boot_loader_pkg::*;
#(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    close_i,
    input  logic                    clear_i,
    input  logic [7:0]              byte_i,
    output logic [8*WORD_BYTES-1:0] word_o,
    output logic                    last_lane_o
);

    localparam int IDX_W = idx_width(WORD_BYTES);

    logic [IDX_W-1:0]        idx_q;
    logic [8*WORD_BYTES-1:0] word_q;
    logic [8*WORD_BYTES-1:0] word_d;

    // word_d already holds the incoming byte, so the top can latch a
    // closing word in the same cycle the last byte is accepted.
    always_comb begin
        word_d = word_q;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                word_d[8*k +: 8] = byte_i;
            end
        end
    end

    assign word_o      = word_d;
    assign last_lane_o = (idx_q == IDX_W'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (push_i) begin
            if (close_i) begin
                idx_q  <= '0;
                word_q <= '0;
            end else begin
                idx_q  <= idx_q + IDX_W'(1);
                word_q <= word_d;
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Serial program loader: header (length, base), little-endian word assembly
// and valid/ready memory writes. BOOT_LOADER_CHECKSUM_EN adds a trailing sum byte.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 32,
    parameter int ADDR_STEP  = WORD_BYTES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    restart,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_data,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    done,
    output logic                    error
);

    localparam int HB     = hdr_field_bytes(ADDR_W);
    localparam int HIDX_W = idx_width(HB);
    localparam int DW     = 8 * WORD_BYTES;

    boot_state_t         state_q;
    logic [HIDX_W-1:0]   hdr_idx_q;
    logic [ADDR_W-1:0]   hdr_sr_q;
    logic [ADDR_W-1:0]   hdr_d;
    logic [ADDR_W-1:0]   remaining_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DW-1:0]       mem_data_q;
    logic                mem_valid_q;
    logic                done_q;
    logic                rx_fire;
    logic                hdr_last;
    logic                pk_push;
    logic                pk_close;
    logic                pk_clear;
    logic                pk_last_lane;
    logic [DW-1:0]       pk_word;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
    logic                error_q;
`endif

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            ST_HDR_LEN, ST_HDR_ADDR, ST_PAYLOAD, ST_CHECK: rx_ready = 1'b1;
            default:                                       rx_ready = 1'b0;
        endcase
    end

    assign rx_fire  = rx_valid && rx_ready;
    assign hdr_last = (hdr_idx_q == HIDX_W'(HB - 1));

    // Header field with the current byte merged into its lane.
    always_comb begin
        hdr_d = hdr_sr_q;
        for (int i = 0; i < HB; i++) begin
            if (hdr_idx_q == HIDX_W'(i)) begin
                hdr_d[8*i +: 8] = rx_data;
            end
        end
    end

    assign pk_push  = rx_fire && (state_q == ST_PAYLOAD);
    assign pk_close = pk_push && (pk_last_lane || (remaining_q == ADDR_W'(1)));
    assign pk_clear = restart && ((state_q == ST_DONE) || (state_q == ST_ERROR));

    byte_packer #(
        .WORD_BYTES (WORD_BYTES)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .push_i      (pk_push),
        .close_i     (pk_close),
        .clear_i     (pk_clear),
        .byte_i      (rx_data),
        .word_o      (pk_word),
        .last_lane_o (pk_last_lane)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HDR_LEN;
            hdr_idx_q   <= '0;
            hdr_sr_q    <= '0;
            remaining_q <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q      <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_HDR_LEN: begin
                    if (rx_fire) begin
                        hdr_sr_q <= hdr_d;
                        if (hdr_last) begin
                            hdr_idx_q   <= '0;
                            remaining_q <= hdr_d;
                            state_q     <= ST_HDR_ADDR;
                        end else begin
                            hdr_idx_q <= hdr_idx_q + HIDX_W'(1);
                        end
                    end
                end
                ST_HDR_ADDR: begin
                    if (rx_fire) begin
                        hdr_sr_q <= hdr_d;
                        if (hdr_last) begin
                            hdr_idx_q  <= '0;
                            mem_addr_q <= hdr_d;
                            if (remaining_q != '0) begin
                                state_q <= ST_PAYLOAD;
                            end else begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                                state_q <= ST_CHECK;
`else
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
`endif
                            end
                        end else begin
                            hdr_idx_q <= hdr_idx_q + HIDX_W'(1);
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_fire) begin
                        remaining_q <= remaining_q - ADDR_W'(1);
`ifdef BOOT_LOADER_CHECKSUM_EN
                        csum_q      <= csum_q + rx_data;
`endif
                        if (pk_close) begin
                            mem_data_q  <= pk_word;
                            mem_valid_q <= 1'b1;
                            state_q     <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(ADDR_STEP);
                        if (remaining_q != '0) begin
                            state_q <= ST_PAYLOAD;
                        end else begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                            state_q <= ST_CHECK;
`else
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (rx_fire) begin
                        if (rx_data == csum_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE, ST_ERROR: begin
                    if (restart) begin
                        state_q     <= ST_HDR_LEN;
                        done_q      <= 1'b0;
                        hdr_idx_q   <= '0;
                        remaining_q <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        csum_q      <= '0;
                        error_q     <= 1'b0;
`endif
                    end
                end
                default: state_q <= ST_HDR_LEN;
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_valid = mem_valid_q;
    assign done      = done_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    assign error     = error_q;
`else
    assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader (default 4-byte words, 32-bit addresses);
// the checksum scenarios run when BOOT_LOADER_CHECKSUM_EN is defined.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic        mem_ready;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    boot_loader dut (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .done      (done),
        .error     (error)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: inputs are driven on the falling edge, so sampling 1
    // time unit later sees exactly what the next rising edge will use.
    always @(negedge clk) begin
        #1;
        if (!reset && mem_valid && mem_ready) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_write", 64'(sb_q.size()), 64'd1);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e[63:32]));
                chk("wr_data", 64'(mem_data), 64'(e[31:0]));
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_ready_timeout", 64'(rx_ready), 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Reference model: pushes the expected writes and returns the byte sum.
    task automatic push_exp(input int len, input logic [31:0] base, input logic [7:0] seed,
                            output logic [7:0] sum);
        logic [31:0] w;
        logic [31:0] a;
        logic [7:0]  b;
        w = '0;
        a = base;
        sum = '0;
        for (int i = 0; i < len; i++) begin
            b = seed + 8'(i);
            w[8*(i%4) +: 8] = b;
            sum = sum + b;
            if ((i % 4) == 3 || i == len - 1) begin
                sb_q.push_back({a, w});
                a = a + 32'd4;
                w = '0;
            end
        end
    endtask

    task automatic send_hdr(input int len, input logic [31:0] base);
        logic [31:0] l;
        l = 32'(len);
        for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(base[8*i +: 8]);
    endtask

    task automatic send_pay(input logic [7:0] seed, input int from, input int to);
        for (int i = from; i < to; i++) send_byte(seed + 8'(i));
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!done && !error && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic full_load(input string tag, input int len, input logic [31:0] base,
                             input logic [7:0] seed, input int exp_wr);
        logic [7:0] sum;
        wr_cnt = 0;
        push_exp(len, base, seed, sum);
        send_hdr(len, base);
        send_pay(seed, 0, len);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(sum);
`endif
        wait_end();
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_nwrites"}, 64'(wr_cnt), 64'(exp_wr));
        chk({tag, "_sb_left"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_done_low", 64'(done), 64'd0);
        chk("restart_error_low", 64'(error), 64'd0);
        chk("restart_rx_ready", 64'(rx_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] hold_addr;
        logic [31:0] hold_data;
        logic [7:0]  sum;

        reset = 1'b1; restart = 1'b0; rx_data = '0; rx_valid = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_data", 64'(mem_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_rx_ready", 64'(rx_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        // Two full words from 0x100.
        full_load("len8", 8, 32'h100, 8'h01, 2);
        do_restart();

        // Partial trailing word is zero-filled.
        full_load("len5", 5, 32'h0, 8'h01, 2);
        do_restart();

        // Back-pressure on the first write.
        mem_ready = 1'b0;
        wr_cnt = 0;
        push_exp(8, 32'h200, 8'h11, sum);
        send_hdr(8, 32'h200);
        send_pay(8'h11, 0, 4);
        chk("stall_valid", 64'(mem_valid), 64'd1);
        hold_addr = mem_addr;
        hold_data = mem_data;
        chk("stall_first_addr", 64'(hold_addr), 64'h200);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall_addr", 64'(mem_addr), 64'(hold_addr));
            chk("stall_data", 64'(mem_data), 64'(hold_data));
            chk("stall_rx_ready", 64'(rx_ready), 64'd0);
        end
        mem_ready = 1'b1;
        send_pay(8'h11, 4, 8);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(sum);
`endif
        wait_end();
        chk("stall_done", 64'(done), 64'd1);
        chk("stall_nwrites", 64'(wr_cnt), 64'd2);
        chk("stall_sb_left", 64'(sb_q.size()), 64'd0);
        do_restart();

        // Zero-length payload.
        wr_cnt = 0;
        send_hdr(0, 32'h40);
`ifdef BOOT_LOADER_CHECKSUM_EN
        chk("len0_check_ready", 64'(rx_ready), 64'd1);
        chk("len0_not_done", 64'(done), 64'd0);
        send_byte(8'h00);
`endif
        chk("len0_done", 64'(done), 64'd1);
        chk("len0_nwrites", 64'(wr_cnt), 64'd0);
        do_restart();

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Good and bad trailing checksum, then recovery via restart.
        push_exp(4, 32'h0, 8'h01, sum);
        chk("cs_model_sum", 64'(sum), 64'h0A);
        send_hdr(4, 32'h0);
        send_pay(8'h01, 0, 4);
        send_byte(8'h0A);
        chk("cs_good_done", 64'(done), 64'd1);
        chk("cs_good_error", 64'(error), 64'd0);
        do_restart();
        push_exp(4, 32'h0, 8'h01, sum);
        send_hdr(4, 32'h0);
        send_pay(8'h01, 0, 4);
        send_byte(8'h0B);
        chk("cs_bad_error", 64'(error), 64'd1);
        chk("cs_bad_done", 64'(done), 64'd0);
        chk("cs_bad_rx_ready", 64'(rx_ready), 64'd0);
        do_restart();
        full_load("cs_reload", 4, 32'h0, 8'h01, 1);
        do_restart();
`else
        full_load("noncs_err", 4, 32'h80, 8'hA0, 1);
        do_restart();
`endif

        // Reset mid-payload drops everything; a fresh stream then loads.
        push_exp(8, 32'h300, 8'h21, sum);
        send_hdr(8, 32'h300);
        send_pay(8'h21, 0, 6);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("mid_rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("mid_rst_mem_data", 64'(mem_data), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_rx_ready", 64'(rx_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        full_load("post_rst", 7, 32'hFFFF_FFF8, 8'h31, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
